sha256_msg_padder: RTL and testbench

//  Upstream feeder for the SHA-256 compression core. Accepts a message as a stream of
//  big-endian 32-bit words, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit
//  bit length) and assembles 512-bit blocks. Drives the core's W0..W15 and A_i..H_i

---
 rtl/sha256_msg_padder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// ============================================================================
// sha256_msg_padder
// ----------------------------------------------------------------------------
// Purpose:
//   Feeds a SHA-256 compression core. Takes a message as big-endian 32-bit
//   words, applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit
//   length), builds 512-bit blocks, starts the core on each block, chains
//   the intermediate hash values and presents the final digest.
//
// Optional feature (compile-time macro):
//   SHA256_PAD_BLKCNT_EN - adds parameter CNT_W and output blk_count: blocks
//                          started for the current message, saturating,
//                          cleared when the digest is delivered.
//
// Ports:
//   clk           in   1    clock, rising edge
//   reset         in   1    asynchronous active-high reset
//   msg_valid     in   1    msg_data/msg_last/msg_bytes valid
//   msg_ready     out  1    word accepted when msg_valid & msg_ready
//   msg_data      in   32   message word, first byte in [31:24]
//   msg_last      in   1    final word of message
//   msg_bytes     in   3    valid bytes in last word (0..4, MSB-aligned)
//   blk_w         out  512  block words, W0 in [511:480] .. W15 in [31:0]
//   blk_iv        out  256  chaining value {A..H} for the core
//   blk_start     out  1    one-cycle start pulse to the core
//   core_done     in   1    core finished (only looked at while waiting)
//   core_result   in   256  core hash output {H0..H7}
//   digest        out  256  final digest, held until next message completes
//   digest_valid  out  1    one-cycle pulse when digest updates
//   busy          out  1    high from first accepted word until digest_valid
//   blk_count     out  CNT_W  (SHA256_PAD_BLKCNT_EN only)
// ============================================================================
//  state   | meaning
//  S_FILL  | accepting message words into blk_w
//  S_PAD   | writing marker / zero / length words, one per cycle
//  S_START | one-cycle start pulse to the core
//  S_WAIT  | block held stable until core_done
// ============================================================================
module sha256_msg_padder #(
    parameter int LEN_W = 64
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_data,
    input  logic         msg_last,
    input  logic [2:0]   msg_bytes,
    output logic [511:0] blk_w,
    output logic [255:0] blk_iv,
    output logic         blk_start,
    input  logic         core_done,
    input  logic [255:0] core_result,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [CNT_W-1:0] blk_count
`endif
);

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_START,
        S_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       word_idx, word_idx_nxt;
    logic [LEN_W-1:0] bit_len, bit_len_nxt;
    logic [511:0]     blk_w_nxt;
    logic [255:0]     blk_iv_nxt;
    logic [255:0]     digest_nxt;
    logic             digest_valid_nxt;
    logic             busy_nxt;

    // mark_pend: last word was full, marker still owed to a later word.
    // mark_done: marker already written somewhere in the padded message.
    // msg_end:   last word accepted; remaining blocks are padding only.
    // need_extra: length did not fit, another block must follow.
    logic mark_pend, mark_pend_nxt;
    logic mark_done, mark_done_nxt;
    logic msg_end, msg_end_nxt;
    logic need_extra, need_extra_nxt;

    logic [2:0]  last_nb;
    logic [31:0] last_word;
    logic [31:0] pad_word;
    logic        blk_final;

    function automatic logic [511:0] put_word(input logic [511:0] blk,
                                              input logic [3:0]   idx,
                                              input logic [31:0]  word);
        logic [511:0] res;
        res = blk;
        res[511 - 32*idx -: 32] = word;
        return res;
    endfunction

    // Last-word formatting: byte counts above 4 behave as 4. The marker
    // byte replaces the first unused byte; bytes after it are cleared.
    always_comb begin
        last_nb = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
        case (last_nb)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {msg_data[31:24], 24'h80_0000};
            3'd2:    last_word = {msg_data[31:16], 16'h8000};
            3'd3:    last_word = {msg_data[31:8], 8'h80};
            default: last_word = msg_data;
        endcase
    end

    always_comb begin
        state_nxt        = state;
        word_idx_nxt     = word_idx;
        bit_len_nxt      = bit_len;
        blk_w_nxt        = blk_w;
        blk_iv_nxt       = blk_iv;
        digest_nxt       = digest;
        digest_valid_nxt = 1'b0;
        busy_nxt         = busy;
        mark_pend_nxt    = mark_pend;
        mark_done_nxt    = mark_done;
        msg_end_nxt      = msg_end;
        need_extra_nxt   = need_extra;
        msg_ready        = 1'b0;
        blk_start        = 1'b0;
        blk_final        = 1'b0;
        pad_word         = 32'h0;

        case (state)
            S_FILL: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    busy_nxt = 1'b1;
                    if (msg_last) begin
                        bit_len_nxt   = bit_len + LEN_W'({last_nb, 3'b000});
                        blk_w_nxt     = put_word(blk_w, word_idx, last_word);
                        mark_pend_nxt = (last_nb == 3'd4);
                        mark_done_nxt = (last_nb != 3'd4);
                        msg_end_nxt   = 1'b1;
                        if (word_idx == 4'd15) begin
                            // Block full: marker and/or length go to the next block.
                            need_extra_nxt = 1'b1;
                            state_nxt      = S_START;
                        end else begin
                            word_idx_nxt = word_idx + 4'd1;
                            state_nxt    = S_PAD;
                        end
                    end else begin
                        bit_len_nxt = bit_len + LEN_W'(32);
                        blk_w_nxt   = put_word(blk_w, word_idx, msg_data);
                        if (word_idx == 4'd15) begin
                            state_nxt = S_START;
                        end else begin
                            word_idx_nxt = word_idx + 4'd1;
                        end
                    end
                end
            end

            S_PAD: begin
                if (mark_done && word_idx == 4'd14) begin
                    blk_w_nxt[63:0] = 64'(bit_len);
                    need_extra_nxt  = 1'b0;
                    state_nxt       = S_START;
                end else begin
                    if (mark_pend) begin
                        pad_word      = 32'h8000_0000;
                        mark_pend_nxt = 1'b0;
                        mark_done_nxt = 1'b1;
                    end
                    blk_w_nxt = put_word(blk_w, word_idx, pad_word);
                    if (word_idx == 4'd15) begin
                        // Length did not fit in this block.
                        need_extra_nxt = 1'b1;
                        state_nxt      = S_START;
                    end else begin
                        word_idx_nxt = word_idx + 4'd1;
                    end
                end
            end

            S_START: begin
                blk_start = 1'b1;
                state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (core_done) begin
                    blk_iv_nxt   = core_result;
                    word_idx_nxt = 4'd0;
                    if (!msg_end) begin
                        state_nxt = S_FILL;
                    end else if (need_extra) begin
                        need_extra_nxt = 1'b0;
                        state_nxt      = S_PAD;
                    end else begin
                        blk_final        = 1'b1;
                        digest_nxt       = core_result;
                        digest_valid_nxt = 1'b1;
                        blk_iv_nxt       = SHA256_IV;
                        bit_len_nxt      = '0;
                        busy_nxt         = 1'b0;
                        mark_pend_nxt    = 1'b0;
                        mark_done_nxt    = 1'b0;
                        msg_end_nxt      = 1'b0;
                        state_nxt        = S_FILL;
                    end
                end
            end

            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_FILL;
            word_idx     <= 4'd0;
            bit_len      <= '0;
            blk_w        <= '0;
            blk_iv       <= SHA256_IV;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            mark_pend    <= 1'b0;
            mark_done    <= 1'b0;
            msg_end      <= 1'b0;
            need_extra   <= 1'b0;
        end else begin
            state        <= state_nxt;
            word_idx     <= word_idx_nxt;
            bit_len      <= bit_len_nxt;
            blk_w        <= blk_w_nxt;
            blk_iv       <= blk_iv_nxt;
            digest       <= digest_nxt;
            digest_valid <= digest_valid_nxt;
            busy         <= busy_nxt;
            mark_pend    <= mark_pend_nxt;
            mark_done    <= mark_done_nxt;
            msg_end      <= msg_end_nxt;
            need_extra   <= need_extra_nxt;
        end
    end

`ifdef SHA256_PAD_BLKCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count <= '0;
        end else if (blk_final) begin
            blk_count <= '0;
        end else if (blk_start && (blk_count != '1)) begin
            blk_count <= blk_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
`timescale 1ns/1ps
module tb_sha256_msg_padder;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [31:0]  msg_data = '0;
    logic         msg_last = 1'b0;
    logic [2:0]   msg_bytes = '0;
    logic [511:0] blk_w;
    logic [255:0] blk_iv;
    logic         blk_start;
    logic         core_done_m;
    logic         stray = 1'b0;
    logic [255:0] core_result;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0]  blk_count;
`endif

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk          (clk),
        .reset        (reset),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_data     (msg_data),
        .msg_last     (msg_last),
        .msg_bytes    (msg_bytes),
        .blk_w        (blk_w),
        .blk_iv       (blk_iv),
        .blk_start    (blk_start),
        .core_done    (core_done_m | stray),
        .core_result  (core_result),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy)
`ifdef SHA256_PAD_BLKCNT_EN
        ,
        .blk_count    (blk_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_blk[$], seen_blk[$];
    logic [255:0] exp_iv[$], seen_iv[$], exp_dig[$], seen_dig[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression (with feed-forward), plays the core.
    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, bb, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Byte-level padding model: queue expected blocks, chaining values, digest.
    task automatic model(input logic [7:0] m [$]);
        logic [7:0]   p [$];
        logic [63:0]  bits;
        logic [255:0] h;
        logic [511:0] blk;
        p = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        h = IV;
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*k + j];
            exp_blk.push_back(blk);
            exp_iv.push_back(h);
            h = compress(h, blk);
        end
        exp_dig.push_back(h);
    endtask

    // Core stand-in: capture each started block, answer after 1..4 cycles.
    initial begin
        logic [255:0] res;
        int lat;
        core_done_m = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            core_done_m = 1'b0;
            core_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (blk_start === 1'b1 && !reset) begin
                seen_blk.push_back(blk_w);
                seen_iv.push_back(blk_iv);
                res = compress(blk_iv, blk_w);
                lat = $urandom_range(1, 4);
                repeat (lat) @(negedge clk);
                core_done_m = 1'b1;
                core_result = res;
            end
        end
    end

    // Digest monitor.
    initial begin
        int blk_since;
`ifdef SHA256_PAD_BLKCNT_EN
        logic [15:0] prev_cnt;
        prev_cnt = '0;
`endif
        blk_since = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                blk_since = 0;
            end else begin
                if (digest_valid === 1'b1) begin
                    seen_dig.push_back(digest);
                    chk("busy_at_digest", 512'(busy), 512'(0));
`ifdef SHA256_PAD_BLKCNT_EN
                    chk("blkcnt_before_digest", 512'(prev_cnt), 512'(blk_since));
                    chk("blkcnt_at_digest", 512'(blk_count), 512'(0));
`endif
                    blk_since = 0;
                end
                if (blk_start === 1'b1) blk_since++;
            end
`ifdef SHA256_PAD_BLKCNT_EN
            prev_cnt = blk_count;
`endif
        end
    end

    task automatic send(input logic [7:0] m [$], input int max_words, input int gap_pct,
                        input bit big, input bit tail);
        int n, nw, cnt, wc;
        logic [31:0] d;
        logic [2:0]  nb;
        n = m.size();
        if (n == 0) nw = 1;
        else if (tail && (n % 4 == 0)) nw = n / 4 + 1;
        else nw = (n + 3) / 4;
        for (int w = 0; w < nw && w < max_words; w++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                msg_valid = 1'b0;
                @(negedge clk);
            end
            cnt = n - 4*w;
            if (cnt > 4) cnt = 4;
            if (cnt < 0) cnt = 0;
            d = $urandom;
            for (int b = 0; b < cnt; b++) d[31 - 8*b -: 8] = m[4*w + b];
            nb = 3'(cnt);
            if (cnt == 4 && big) nb = 3'($urandom_range(5, 7));
            msg_valid = 1'b1;
            msg_data  = d;
            msg_last  = (w == nw - 1);
            msg_bytes = (w == nw - 1) ? nb : 3'($urandom);
            wc = 0;
            while (msg_ready !== 1'b1 && wc < 2000) begin
                @(negedge clk);
                wc++;
            end
            if (msg_ready !== 1'b1) begin
                fail_timeout("send_ready");
                msg_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_digests(input string name);
        int wc;
        wc = 0;
        while (seen_dig.size() < exp_dig.size() && wc < 3000) begin
            @(negedge clk);
            wc++;
        end
        if (seen_dig.size() < exp_dig.size()) fail_timeout({name, "_digest"});
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_and_clear(input string name);
        chk({name, "_nblk"}, 512'(seen_blk.size()), 512'(exp_blk.size()));
        for (int i = 0; i < seen_blk.size() && i < exp_blk.size(); i++) begin
            chk($sformatf("%s_blk%0d", name, i), seen_blk[i], exp_blk[i]);
            chk($sformatf("%s_iv%0d", name, i), 512'(seen_iv[i]), 512'(exp_iv[i]));
        end
        chk({name, "_ndig"}, 512'(seen_dig.size()), 512'(exp_dig.size()));
        for (int i = 0; i < seen_dig.size() && i < exp_dig.size(); i++)
            chk($sformatf("%s_dig%0d", name, i), 512'(seen_dig[i]), 512'(exp_dig[i]));
        exp_blk.delete(); seen_blk.delete(); exp_iv.delete(); seen_iv.delete();
        exp_dig.delete(); seen_dig.delete();
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_blk_w"}, blk_w, 512'(0));
        chk({name, "_blk_iv"}, 512'(blk_iv), 512'(IV));
        chk({name, "_digest"}, 512'(digest), 512'(0));
        chk({name, "_blk_start"}, 512'(blk_start), 512'(0));
        chk({name, "_digest_valid"}, 512'(digest_valid), 512'(0));
        chk({name, "_busy"}, 512'(busy), 512'(0));
        chk({name, "_msg_ready"}, 512'(msg_ready), 512'(1));
    endtask

    typedef struct {
        string        name;
        logic [511:0] msg;
        int           len;
        logic [255:0] dig;
        int           nblk;
        logic [31:0]  w0;
        logic [31:0]  w15;
    } vec_t;

    function automatic void bytes_of(input logic [511:0] msg, input int len, output logic [7:0] q [$]);
        q.delete();
        for (int i = 0; i < len; i++) q.push_back(msg[8*(len - 1 - i) +: 8]);
    endfunction

    initial begin
        vec_t         vecs [3];
        logic [7:0]   q [$];
        logic [7:0]   q2 [$];
        logic [511:0] s56;
        int           lens [17];
        int           wc;

        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        vecs[0] = '{name: "abc", msg: 512'h616263, len: 3, dig: DIG_ABC, nblk: 1,
                    w0: 32'h61626380, w15: 32'h18};
        vecs[1] = '{name: "empty", msg: '0, len: 0, dig: DIG_EMPTY, nblk: 1,
                    w0: 32'h80000000, w15: 32'h0};
        vecs[2] = '{name: "s56", msg: s56, len: 56, dig: DIG_56, nblk: 2,
                    w0: 32'h61626364, w15: 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 512'(msg_ready), 512'(1));

        // Known-answer table
        for (int v = 0; v < 3; v++) begin
            bytes_of(vecs[v].msg, vecs[v].len, q);
            model(q);
            send(q, 1000, 0, 1'b0, 1'b0);
            wait_digests(vecs[v].name);
            chk({vecs[v].name, "_nblk_tbl"}, 512'(seen_blk.size()), 512'(vecs[v].nblk));
            if (seen_blk.size() > 0) begin
                chk({vecs[v].name, "_w0"}, 512'(seen_blk[0][511:480]), 512'(vecs[v].w0));
                chk({vecs[v].name, "_w15"}, 512'(seen_blk[0][31:0]), 512'(vecs[v].w15));
            end
            if (seen_dig.size() > 0)
                chk({vecs[v].name, "_digest_kat"}, 512'(seen_dig[0]), 512'(vecs[v].dig));
            if (v == 2 && seen_blk.size() > 1) begin
                chk("s56_b1_w14", 512'(seen_blk[0][63:32]), 512'(32'h80000000));
                chk("s56_b2_w15", 512'(seen_blk[1][31:0]), 512'(32'h1c0));
                chk("s56_b2_w0_14", seen_blk[1][511:32], 512'(0));
            end
            compare_and_clear(vecs[v].name);
        end

        // Back-to-back: "abc" then empty
        bytes_of(vecs[0].msg, 3, q);
        bytes_of(vecs[1].msg, 0, q2);
        model(q);
        model(q2);
        send(q, 1000, 0, 1'b0, 1'b0);
        send(q2, 1000, 0, 1'b0, 1'b0);
        wait_digests("b2b");
        chk("b2b_ndig", 512'(seen_dig.size()), 512'(2));
        if (seen_dig.size() > 1) begin
            chk("b2b_dig_abc", 512'(seen_dig[0]), 512'(DIG_ABC));
            chk("b2b_dig_empty", 512'(seen_dig[1]), 512'(DIG_EMPTY));
        end
        compare_and_clear("b2b");

        // Backpressure with valid held high, stray core_done while filling
        q.delete();
        for (int i = 0; i < 100; i++) q.push_back(8'($urandom));
        model(q);
        fork
            send(q, 1000, 0, 1'b0, 1'b0);
            begin
                repeat (5) @(negedge clk);
                stray = 1'b1;
                @(negedge clk);
                stray = 1'b0;
                wc = 0;
                while (blk_start !== 1'b1 && wc < 200) begin
                    @(negedge clk);
                    wc++;
                end
                if (blk_start !== 1'b1) fail_timeout("bp_start");
                @(negedge clk);
                chk("bp_valid_held", 512'(msg_valid), 512'(1));
                chk("bp_ready_low", 512'(msg_ready), 512'(0));
                chk("bp_busy", 512'(busy), 512'(1));
            end
        join
        wait_digests("bp");
        compare_and_clear("bp");

        // Reset while waiting on the core, then rerun "abc"
        q.delete();
        for (int i = 0; i < 100; i++) q.push_back(8'($urandom));
        send(q, 16, 0, 1'b0, 1'b0);
        wc = 0;
        while (blk_start !== 1'b1 && wc < 200) begin
            @(negedge clk);
            wc++;
        end
        if (blk_start !== 1'b1) fail_timeout("rstw_start");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("rstw");
        @(negedge clk);
        check_reset_values("rstw_next");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        exp_blk.delete(); seen_blk.delete(); exp_iv.delete(); seen_iv.delete();
        exp_dig.delete(); seen_dig.delete();
        bytes_of(vecs[0].msg, 3, q);
        model(q);
        send(q, 1000, 0, 1'b0, 1'b0);
        wait_digests("rerun");
        if (seen_dig.size() > 0) chk("rerun_digest_kat", 512'(seen_dig[0]), 512'(DIG_ABC));
        compare_and_clear("rerun");

        // Randomized messages around padding boundaries
        lens = '{52, 55, 56, 57, 60, 63, 64, 65, 119, 120, 128, 4,
                 0, 0, 0, 0, 0};
        for (int i = 12; i < 17; i++) lens[i] = $urandom_range(0, 200);
        for (int t = 0; t < 17; t++) begin
            q.delete();
            for (int i = 0; i < lens[t]; i++) q.push_back(8'($urandom));
            model(q);
            send(q, 1000, $urandom_range(0, 30), 1'($urandom), 1'($urandom));
            wait_digests($sformatf("rnd%0d", t));
            compare_and_clear($sformatf("rnd%0d_len%0d", t, lens[t]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
